// File: rtl/mem_access_unit_if.sv
// Data-bus req/ack interface between the MEM-stage access unit (master) and data memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack bus handshake, pipeline stall, load extraction, bus timeout.
// Optional misaligned-access check is enabled by defining MEM_MISALIGN_CHK_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exmem_mem_r,
    input  logic              exmem_mem_w,
    input  logic              mem_nop,
    input  logic [31:0]       exmem_excepttype,
    input  logic [31:0]       exmem_alu_res,
    input  logic [31:0]       exmem_aligned_rt_data,
    input  logic [3:0]        mem_byte_w_en,
    input  logic [2:0]        exmem_load_sel,
    mem_access_unit_if.master bus,
    output logic              mem_stall,
    output logic [31:0]       mem_load_data,
    output logic              mem_bus_err,
    output logic [1:0]        mem_addr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [31:0]       r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [3:0]        r_bus_be;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_load_data;
    logic              r_bus_err;
    logic [2:0]        r_sel;
    logic [1:0]        r_addr_lo;

    logic              w_valid;
    logic              w_pending;
    logic              w_issue;
    logic              w_ack;
    logic              w_abort;
    logic [31:0]       w_load_ext;

    assign w_valid = !mem_nop && (exmem_excepttype == 32'd0);

`ifdef MEM_MISALIGN_CHK_EN
    logic w_is_lh;
    logic w_is_lw;
    logic w_ld_mis;
    logic w_st_mis;

    // Unknown load selects behave as LW, so they carry the word alignment rule too.
    assign w_is_lh  = (exmem_load_sel == 3'b011) || (exmem_load_sel == 3'b100);
    assign w_is_lw  = !(w_is_lh || (exmem_load_sel == 3'b001) || (exmem_load_sel == 3'b010));
    assign w_ld_mis = exmem_mem_r &&
                      ((w_is_lw && (exmem_alu_res[1:0] != 2'b00)) || (w_is_lh && exmem_alu_res[0]));
    assign w_st_mis = exmem_mem_w &&
                      (((mem_byte_w_en == 4'b1111) && (exmem_alu_res[1:0] != 2'b00)) ||
                       (((mem_byte_w_en == 4'b0011) || (mem_byte_w_en == 4'b1100)) && exmem_alu_res[0]));
    assign w_pending    = (exmem_mem_r || exmem_mem_w) && w_valid && !w_ld_mis && !w_st_mis;
    assign mem_addr_err = {w_valid && w_st_mis, w_valid && w_ld_mis};
`else
    assign w_pending    = (exmem_mem_r || exmem_mem_w) && w_valid;
    assign mem_addr_err = 2'b00;
`endif

    // Extraction uses the select and offset latched at issue, so EX/MEM changes during REQ cannot corrupt it.
    always_comb begin
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        case (r_addr_lo)
            2'b00:   v_byte = bus.bus_rdata[7:0];
            2'b01:   v_byte = bus.bus_rdata[15:8];
            2'b10:   v_byte = bus.bus_rdata[23:16];
            default: v_byte = bus.bus_rdata[31:24];
        endcase
        v_half = r_addr_lo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (r_sel)
            3'b001:  w_load_ext = {{24{v_byte[7]}}, v_byte};
            3'b010:  w_load_ext = {24'd0, v_byte};
            3'b011:  w_load_ext = {{16{v_half[15]}}, v_half};
            3'b100:  w_load_ext = {16'd0, v_half};
            default: w_load_ext = bus.bus_rdata;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        mem_stall   = 1'b0;
        w_issue     = 1'b0;
        w_ack       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    w_state_nxt = REQ;
                    w_issue     = 1'b1;
                    mem_stall   = 1'b1;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (bus.bus_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State moves on the falling edge, in step with the pipeline registers around this stage.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(negedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
            r_cnt       <= '0;
            r_load_data <= 32'd0;
            r_bus_err   <= 1'b0;
            r_sel       <= 3'd0;
            r_addr_lo   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= exmem_mem_w;
                r_bus_addr  <= {exmem_alu_res[31:2], 2'b00};
                r_bus_wdata <= exmem_aligned_rt_data;
                r_bus_be    <= exmem_mem_w ? mem_byte_w_en : 4'b1111;
                r_cnt       <= '0;
                r_bus_err   <= 1'b0;
                r_sel       <= exmem_load_sel;
                r_addr_lo   <= exmem_alu_res[1:0];
            end
            if (w_ack) begin
                r_bus_req <= 1'b0;
                if (!r_bus_we) begin
                    r_load_data <= w_load_ext;
                end
            end else if (w_abort) begin
                r_bus_req   <= 1'b0;
                r_bus_err   <= 1'b1;
                r_load_data <= 32'd0;
            end else if (r_state == REQ) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.bus_req    = r_bus_req;
    assign bus.bus_we     = r_bus_we;
    assign bus.bus_addr   = r_bus_addr;
    assign bus.bus_wdata  = r_bus_wdata;
    assign bus.bus_be     = r_bus_be;
    assign mem_load_data  = r_load_data;
    assign mem_bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a default-timeout instance and a TIMEOUT_CYCLES=4 instance share stimulus.
module tb_mem_access_unit;

    localparam int TO_CYCLES = 4;

    typedef struct {
        bit          to;
        logic        rd;
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          lat;
        bit          scramble;
        logic [31:0] exp_load;
        logic        exp_err;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] load;
        logic        err;
        int          stall;
        int          nreq;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        mem_r;
    logic        mem_w;
    logic        nop;
    logic [31:0] exc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [2:0]  sel;
    logic        use_to;
    logic        ack_drv;
    logic [31:0] rdata_drv;

    logic        m_stall, t_stall, m_err, t_err;
    logic [31:0] m_load, t_load;
    logic [1:0]  m_aerr, t_aerr;

    logic        w_req, w_we, w_stall, w_err;
    logic [31:0] w_addr, w_wdata, w_load;
    logic [3:0]  w_be;
    logic [1:0]  w_aerr;

    int n_checks = 0;
    int n_err    = 0;
    exp_t sb[$];
    vec_t vecs[13];
    logic [31:0] last_main_load;

    mem_access_unit_if bm ();
    mem_access_unit_if bto ();

    assign bm.bus_ack    = ack_drv & !use_to;
    assign bm.bus_rdata  = rdata_drv;
    assign bto.bus_ack   = ack_drv & use_to;
    assign bto.bus_rdata = rdata_drv;

    mem_access_unit u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .exmem_mem_r           (mem_r & !use_to),
        .exmem_mem_w           (mem_w & !use_to),
        .mem_nop               (nop),
        .exmem_excepttype      (exc),
        .exmem_alu_res         (alu),
        .exmem_aligned_rt_data (wd),
        .mem_byte_w_en         (be),
        .exmem_load_sel        (sel),
        .bus                   (bm.master),
        .mem_stall             (m_stall),
        .mem_load_data         (m_load),
        .mem_bus_err           (m_err),
        .mem_addr_err          (m_aerr)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(TO_CYCLES)) u_dut_to (
        .clk                   (clk),
        .reset                 (reset),
        .exmem_mem_r           (mem_r & use_to),
        .exmem_mem_w           (mem_w & use_to),
        .mem_nop               (nop),
        .exmem_excepttype      (exc),
        .exmem_alu_res         (alu),
        .exmem_aligned_rt_data (wd),
        .mem_byte_w_en         (be),
        .exmem_load_sel        (sel),
        .bus                   (bto.master),
        .mem_stall             (t_stall),
        .mem_load_data         (t_load),
        .mem_bus_err           (t_err),
        .mem_addr_err          (t_aerr)
    );

    assign w_req   = use_to ? bto.bus_req   : bm.bus_req;
    assign w_we    = use_to ? bto.bus_we    : bm.bus_we;
    assign w_addr  = use_to ? bto.bus_addr  : bm.bus_addr;
    assign w_wdata = use_to ? bto.bus_wdata : bm.bus_wdata;
    assign w_be    = use_to ? bto.bus_be    : bm.bus_be;
    assign w_stall = use_to ? t_stall : m_stall;
    assign w_err   = use_to ? t_err   : m_err;
    assign w_load  = use_to ? t_load  : m_load;
    assign w_aerr  = use_to ? t_aerr  : m_aerr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit to, logic rd, logic wr, logic [2:0] s, logic [31:0] a,
                                logic [31:0] d, logic [3:0] b, logic [31:0] rdat, int lat,
                                bit scr, logic [31:0] el, logic ee, int es);
        vec_t v;
        v.to = to; v.rd = rd; v.wr = wr; v.sel = s; v.addr = a; v.wdata = d; v.be = b;
        v.rdata = rdat; v.lat = lat; v.scramble = scr;
        v.exp_load = el; v.exp_err = ee; v.exp_stall = es;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_r = 1'b0; mem_w = 1'b0; nop = 1'b0; exc = 32'd0;
        ack_drv = 1'b0; rdata_drv = 32'd0;
    endtask

    // Drives one access from a posedge, answers the bus after v.lat REQ cycles (0 = never) and scores the result.
    task automatic do_access(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        int   nstall = 0;
        int   nreq   = 0;
        bit   done   = 1'b0;
        bit   stable = 1'b1;
        @(posedge clk);
        e.addr  = {v.addr[31:2], 2'b00};
        e.wdata = v.wdata;
        e.be    = v.wr ? v.be : 4'b1111;
        e.we    = v.wr;
        e.load  = v.exp_load;
        e.err   = v.exp_err;
        e.stall = v.exp_stall;
        e.nreq  = (v.lat == 0) ? TO_CYCLES : v.lat;
        sb.push_back(e);
        use_to = v.to; mem_r = v.rd; mem_w = v.wr; sel = v.sel; alu = v.addr;
        wd = v.wdata; be = v.be; nop = 1'b0; exc = 32'd0;
        ack_drv = 1'b0; rdata_drv = ~v.rdata;
        #1;
        check({tag, " addr_err"}, 32'(w_aerr), 32'd0);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc != 0) #1;
            if (!w_stall) begin
                done = 1'b1;
            end else begin
                nstall++;
                @(posedge clk);
                ack_drv = 1'b0; rdata_drv = ~v.rdata;
                if (w_req) begin
                    nreq++;
                    if (nreq == 1) begin
                        check({tag, " bus_addr"},  w_addr,  e.addr);
                        check({tag, " bus_be"},    32'(w_be), 32'(e.be));
                        check({tag, " bus_we"},    32'(w_we), 32'(e.we));
                        check({tag, " bus_err_clr"}, 32'(w_err), 32'd0);
                        if (v.wr) check({tag, " bus_wdata"}, w_wdata, e.wdata);
                    end else if (w_addr !== e.addr || w_be !== e.be || w_we !== e.we ||
                                 (v.wr && w_wdata !== e.wdata)) begin
                        stable = 1'b0;
                    end
                    if (v.lat != 0 && nreq == v.lat) begin
                        ack_drv = 1'b1; rdata_drv = v.rdata;
                    end
                    if (v.scramble && nreq >= 2) begin
                        alu = alu ^ 32'h0000_F003;
                        sel = 3'b001;
                    end
                end
            end
        end
        if (!done) check({tag, " completion_within_budget"}, 32'd0, 32'd1);
        got = sb.pop_front();
        check({tag, " stall_cycles"}, 32'(nstall), 32'(got.stall));
        check({tag, " req_cycles"},   32'(nreq),   32'(got.nreq));
        check({tag, " req_stable"},   32'(stable), 32'd1);
        check({tag, " load_data"},    w_load,      got.load);
        check({tag, " bus_err"},      32'(w_err),  32'(got.err));
        // Keep the instruction in EX/MEM across the DONE edge: a reissue from DONE would show up as bus_req.
        @(negedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        check({tag, " no_reissue"}, 32'(w_req), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        bit   seen_req;
        bit   seen_stall;
        vec_t mv;

        idle_inputs();
        use_to = 1'b0; alu = 32'd0; wd = 32'd0; be = 4'd0; sel = 3'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        #1;
        check("reset bus_req",   32'(w_req),   32'd0);
        check("reset bus_we",    32'(w_we),    32'd0);
        check("reset bus_addr",  w_addr,       32'd0);
        check("reset bus_wdata", w_wdata,      32'd0);
        check("reset bus_be",    32'(w_be),    32'd0);
        check("reset stall",     32'(w_stall), 32'd0);
        check("reset load",      w_load,       32'd0);
        check("reset bus_err",   32'(w_err),   32'd0);
        check("reset to_load",   t_load,       32'd0);

        //           to  rd    wr    sel     addr          wdata         be       rdata         lat scr exp_load      err  stall
        vecs[0]  = mk(0, 1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,        4'b0101, 32'h80FF_1234, 1, 0, 32'hFFFF_FF80, 1'b0, 2);
        vecs[1]  = mk(0, 1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'h0,        4'b0000, 32'hBEEF_0001, 5, 1, 32'h0000_BEEF, 1'b0, 6);
        vecs[2]  = mk(0, 1'b0, 1'b1, 3'b000, 32'h0000_0400, 32'hDEAD_BEEF, 4'b1111, 32'h1111_1111, 2, 0, 32'h0000_BEEF, 1'b0, 3);
        vecs[3]  = mk(0, 1'b1, 1'b0, 3'b011, 32'h0000_0300, 32'h0,        4'b0000, 32'h1234_8001, 1, 0, 32'hFFFF_8001, 1'b0, 2);
        vecs[4]  = mk(0, 1'b1, 1'b0, 3'b010, 32'h0000_0501, 32'h0,        4'b0000, 32'h1122_F3AA, 3, 0, 32'h0000_00F3, 1'b0, 4);
        vecs[5]  = mk(0, 1'b1, 1'b0, 3'b000, 32'h0000_0600, 32'h0,        4'b0000, 32'hCAFE_F00D, 2, 0, 32'hCAFE_F00D, 1'b0, 3);
        vecs[6]  = mk(0, 1'b0, 1'b1, 3'b000, 32'h0000_0703, 32'h5500_0000, 4'b1000, 32'h2222_2222, 1, 0, 32'hCAFE_F00D, 1'b0, 2);
        vecs[7]  = mk(0, 1'b1, 1'b0, 3'b111, 32'h0000_0800, 32'h0,        4'b0000, 32'h0BAD_BEEF, 1, 0, 32'h0BAD_BEEF, 1'b0, 2);
        vecs[8]  = mk(0, 1'b1, 1'b0, 3'b001, 32'h0000_0900, 32'h0,        4'b0000, 32'h0000_007F, 1, 0, 32'h0000_007F, 1'b0, 2);
        vecs[9]  = mk(1, 1'b1, 1'b0, 3'b000, 32'h0000_1000, 32'h0,        4'b0000, 32'hFFFF_0000, 2, 0, 32'hFFFF_0000, 1'b0, 3);
        vecs[10] = mk(1, 1'b1, 1'b0, 3'b000, 32'h0000_1010, 32'h0,        4'b0000, 32'h5555_5555, 0, 0, 32'h0000_0000, 1'b1, 5);
        vecs[11] = mk(1, 1'b1, 1'b0, 3'b000, 32'h0000_1014, 32'h0,        4'b0000, 32'h1357_9BDF, 1, 0, 32'h1357_9BDF, 1'b0, 2);
        vecs[12] = mk(1, 1'b1, 1'b0, 3'b011, 32'h0000_1022, 32'h0,        4'b0000, 32'h8765_4321, 4, 0, 32'hFFFF_8765, 1'b0, 5);

        last_main_load = 32'd0;
        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i], $sformatf("vec%0d", i));
            if (!vecs[i].to) last_main_load = vecs[i].exp_load;
        end

        // Spurious ack while idle must not capture data.
        @(posedge clk);
        use_to = 1'b0; ack_drv = 1'b1; rdata_drv = 32'h1234_5678;
        @(posedge clk);
        ack_drv = 1'b0;
        #1;
        check("spurious_ack load", w_load, last_main_load);
        check("spurious_ack req",  32'(w_req), 32'd0);

        // Suppressed requests: bubble, then exception.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            use_to = 1'b0; mem_r = 1'b1; sel = 3'b000; alu = 32'h0000_0A00;
            nop = (k == 0); exc = (k == 0) ? 32'd0 : 32'h0000_0020;
            seen_req = 1'b0; seen_stall = 1'b0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (w_stall) seen_stall = 1'b1;
                @(posedge clk);
                if (w_req) seen_req = 1'b1;
            end
            check($sformatf("suppress%0d req", k),   32'(seen_req),   32'd0);
            check($sformatf("suppress%0d stall", k), 32'(seen_stall), 32'd0);
            idle_inputs();
        end

`ifdef MEM_MISALIGN_CHK_EN
        @(posedge clk);
        use_to = 1'b0; mem_r = 1'b1; sel = 3'b000; alu = 32'h0000_0102;
        seen_req = 1'b0; seen_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (w_stall) seen_stall = 1'b1;
            if (c == 0) check("misalign_lw addr_err", 32'(w_aerr), 32'd1);
            @(posedge clk);
            if (w_req) seen_req = 1'b1;
        end
        check("misalign_lw req",   32'(seen_req),   32'd0);
        check("misalign_lw stall", 32'(seen_stall), 32'd0);
        check("misalign_lw load",  w_load, last_main_load);
        sel = 3'b100; alu = 32'h0000_0203;
        #1;
        check("misalign_lhu addr_err", 32'(w_aerr), 32'd1);
        mem_r = 1'b0; mem_w = 1'b1; be = 4'b1111; alu = 32'h0000_0401;
        #1;
        check("misalign_sw addr_err", 32'(w_aerr), 32'd2);
        check("misalign_sw stall",    32'(w_stall), 32'd0);
        idle_inputs();
`else
        mv = mk(0, 1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 4'b0000, 32'hA5A5_5A5A, 1, 0,
                32'hA5A5_5A5A, 1'b0, 2);
        do_access(mv, "unaligned_lw");
`endif

        // Reset during the third REQ cycle of an unanswered load.
        @(posedge clk);
        use_to = 1'b0; mem_r = 1'b1; sel = 3'b000; alu = 32'h0000_0040; ack_drv = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge clk);
            if (w_req) n++;
        end
        check("rst_mid third_req_reached", 32'(n), 32'd3);
        reset = 1'b1; mem_r = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid bus_req",  32'(w_req),   32'd0);
        check("rst_mid stall",    32'(w_stall), 32'd0);
        check("rst_mid load",     w_load,       32'd0);
        check("rst_mid bus_addr", w_addr,       32'd0);
        check("rst_mid bus_be",   32'(w_be),    32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller, directly downstream of the EX/MEM pipeline register; consumes its access controls, address, store data and load select.
- Runs a req/ack handshake to the data bus and stalls the pipeline until the access completes.
- Extracts and extends load data for the MEM/WB register.
- Bounds every bus wait with a timeout counter.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ without bus_ack before abort (1..65535).
- CNT_W, 16, timeout counter width.

Ports:
- clk  in  1  sole clock; all state updates on falling edge, same as pipeline registers
- reset  in  1  synchronous, active-high
- exmem_mem_r  in  1  load request
- exmem_mem_w  in  1  store request
- mem_nop  in  1  bubble in MEM; suppresses access
- exmem_excepttype  in  32  non-zero suppresses access
- exmem_alu_res  in  32  effective address
- exmem_aligned_rt_data  in  32  store data, pre-aligned
- mem_byte_w_en  in  4  store byte enables
- exmem_load_sel  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others treated as LW
- bus_req  out  1  access request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables (4'b1111 for reads)
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe
- mem_stall  out  1  to control unit; freezes PC..EX/MEM
- mem_load_data  out  32  extended load result
- mem_bus_err  out  1  timeout abort flag
- mem_addr_err  out  2  {store_err, load_err}; see Optional Feature

Behaviour:
- pending = (exmem_mem_r | exmem_mem_w) & !mem_nop & (exmem_excepttype == 0) [& !misalign when feature on].
- FSM states: IDLE, REQ, DONE. Reset: state IDLE; all outputs, counter and data registers 0.
- IDLE: pending -> REQ. On that edge register bus_req=1, bus_we=exmem_mem_w, bus_addr, bus_wdata, bus_be (reads 4'b1111), counter=0.
- REQ: outputs held stable until bus_ack sampled high.
  - Ack -> DONE; bus_req=0; load data captured if read.
  - No ack: counter+1. Counter == TIMEOUT_CYCLES-1 with no ack -> DONE, bus_req=0, mem_bus_err=1, mem_load_data=0.
- DONE: one cycle, unconditional -> IDLE. No issue from DONE, so the completed instruction is not reissued while still in EX/MEM.
- mem_stall (combinational) = (IDLE & pending) | REQ. Low in DONE, so the pipeline advances on that edge.
  - Minimum access cost: 2 stall cycles (ack in first REQ cycle).
- Load extraction, sel on addr[1:0]:
  - LB/LBU: byte addr[1:0], sign/zero extended.
  - LH/LHU: half addr[1]; addr[0] ignored when feature off.
  - LW: whole word.
- mem_load_data held from capture until the next read capture or reset; stores do not change it.
- mem_bus_err: set on timeout; cleared on next IDLE->REQ issue or reset.
- Ack in IDLE or DONE (spurious): ignored.
- Ack coincident with the timeout edge: ack wins, no error.
- Reset mid-REQ: bus_req drops on the reset edge; state IDLE; no data capture.
- Inputs changing during REQ are ignored (registered bus outputs); EX/MEM is stalled regardless.

Optional Feature:
- Macro MEM_MISALIGN_CHK_EN.
- Defined:
  - misalign = (LW & addr[1:0]!=0) | ((LH|LHU) & addr[0]) for loads; (be==4'b1111 & addr[1:0]!=0) | (be in {0011,1100} & addr[0]) for stores.
  - Misaligned access: never issued, no stall.
  - mem_addr_err[0] (load) or [1] (store) driven combinationally high while the instruction sits in MEM; mem_load_data unchanged.
- Undefined: mem_addr_err tied 0; addresses used as given, low bits ignored per extraction rules.

Test Plan:
- LB at addr 0x103, ack in first REQ cycle with rdata 0x80FF_1234 -> stall exactly 2 cycles, bus_addr=0x100, be=1111, mem_load_data=0xFFFF_FF80.
- LHU at 0x202, ack after 5 cycles, rdata 0xBEEF_0001 -> stall 6 cycles, req stable throughout, mem_load_data=0x0000_BEEF.
- SW at 0x400, data 0xDEADBEEF, be 1111 -> bus_we=1, wdata=0xDEADBEEF; mem_load_data keeps its prior value; single DONE, no reissue.
- No ack, TIMEOUT_CYCLES=4 -> bus_req drops after 4 REQ cycles, mem_bus_err=1, mem_load_data=0, stall released; next access clears mem_bus_err.
- Suppression: mem_r=1 with mem_nop=1, then with excepttype=0x20 -> bus_req never high, mem_stall 0.
- Reset asserted in the 3rd REQ cycle -> next edge bus_req=0, state IDLE, outputs 0; (MEM_MISALIGN_CHK_EN) LW at 0x102 -> mem_addr_err=2'b01, no bus_req.
